// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller.
// Holds the fetch PC, presents it to a combinational fetch stage, and queues
// the returned {pc, instr} words in a 2-entry buffer drained by decode.
// Execute can redirect the PC (flushing the buffer); a misaligned redirect
// target or a halt request parks the controller in HALT until reset.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   pc_o_bus_info     : current PC driven to the fetch stage
//   fetch_i_bus_info  : {pc, instr} returned by fetch for pc_o_bus_info
//   redirect_valid_i  : redirect request; redirect_pc_i is the target
//   halt_i            : stop fetching (sticky until reset)
//   dec_valid_o       : buffer head valid towards decode
//   dec_ready_i       : decode accepts the head entry
//   dec_bus_o         : {pc, instr} at buffer head
//   misalign_o        : sticky, set by a redirect to a non word-aligned target
//   state_o           : 00 BOOT, 01 RUN, 10 HALT
//   fetch_cnt_o       : number of entries pushed since reset
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_o_bus_info,
  input  logic [95:0] fetch_i_bus_info,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [95:0] dec_bus_o,
  output logic        misalign_o,
  output logic [1:0]  state_o,
  output logic [63:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [95:0] fifo [2];
  logic [1:0]  count, count_nxt;
  logic        wr_ptr, rd_ptr;
  logic        misalign, misalign_nxt;
  logic [63:0] fetch_cnt;
  logic        push, pop, flush;
  logic        dec_valid;

  // A redirect in RUN hides the head so nothing is consumed from the path
  // being discarded; in HALT redirects are ignored, so the head stays visible.
  assign dec_valid = (count != 2'd0) && !(redirect_valid_i && (state != HALT));
  assign pop       = dec_valid && dec_ready_i;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    misalign_nxt = misalign;
    push         = 1'b0;
    flush        = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (redirect_valid_i) begin
          flush = 1'b1;
          if (redirect_pc_i[1:0] == 2'b00) begin
            pc_nxt = redirect_pc_i;
          end else begin
            misalign_nxt = 1'b1;
            state_nxt    = HALT;
          end
          // Redirect is applied first, then a simultaneous halt still wins.
          if (halt_i) state_nxt = HALT;
        end else if (halt_i) begin
          state_nxt = HALT;
        end else if ((count != 2'd2) || pop) begin
          // When full, a same-cycle pop frees the slot this push writes.
          push   = 1'b1;
          pc_nxt = pc + 64'd4;
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 2'd1;
        2'b01:   count_nxt = count - 2'd1;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      misalign  <= 1'b0;
      fetch_cnt <= 64'd0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      count     <= count_nxt;
      misalign  <= misalign_nxt;
      fetch_cnt <= fetch_cnt + 64'(push);
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Buffer storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= fetch_i_bus_info;
  end

  assign pc_o_bus_info = pc;
  assign dec_valid_o   = dec_valid;
  assign dec_bus_o     = fifo[rd_ptr];
  assign misalign_o    = misalign;
  assign state_o       = state;
  assign fetch_cnt_o   = fetch_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a queue-based reference
// model compared every cycle, plus literal expectations per scenario.
module tb_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_o;
  logic [95:0] fetch_bus;
  logic        redir;
  logic [63:0] redir_pc;
  logic        halt;
  logic        dec_valid;
  logic        dec_ready;
  logic [95:0] dec_bus;
  logic        misalign;
  logic [1:0]  state;
  logic [63:0] fcnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] p);
    return p[31:0] ^ p[63:32] ^ 32'hDEAD_BEEF;
  endfunction

  // Combinational fetch stage: returns {pc, instr} for the presented PC.
  assign fetch_bus = {pc_o, instr_of(pc_o)};

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_o_bus_info    (pc_o),
    .fetch_i_bus_info (fetch_bus),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .halt_i           (halt),
    .dec_valid_o      (dec_valid),
    .dec_ready_i      (dec_ready),
    .dec_bus_o        (dec_bus),
    .misalign_o       (misalign),
    .state_o          (state),
    .fetch_cnt_o      (fcnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer as a queue, state as 0 BOOT / 1 RUN / 2 HALT.
  logic [95:0] mq [$];
  logic [63:0] m_pc;
  logic [63:0] m_cnt;
  int          m_state;
  logic        m_mis;
  bit          chk_en = 1'b0;

  initial begin
    bit mv, mpop;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_pc = RESET_PC; m_state = 0; m_mis = 1'b0; m_cnt = 64'd0;
      end else begin
        mv   = (mq.size() != 0) && !(redir && m_state != 2);
        mpop = mv && dec_ready;
        if (m_state == 0) begin
          m_state = 1;
        end else if (m_state == 1) begin
          if (redir) begin
            mq.delete();
            if (redir_pc[1:0] == 2'b00) m_pc = redir_pc;
            else begin m_mis = 1'b1; m_state = 2; end
            if (halt) m_state = 2;
          end else begin
            if (mpop) void'(mq.pop_front());
            if (halt) m_state = 2;
            else if (mq.size() < 2) begin
              mq.push_back({m_pc, instr_of(m_pc)});
              m_pc  = m_pc + 64'd4;
              m_cnt = m_cnt + 64'd1;
            end
          end
        end else begin
          if (mpop) void'(mq.pop_front());
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ev = (mq.size() != 0) && !(redir && m_state != 2);
        chk("m_pc",        96'(pc_o),      96'(m_pc));
        chk("m_state",     96'(state),     96'(m_state));
        chk("m_misalign",  96'(misalign),  96'(m_mis));
        chk("m_fetch_cnt", 96'(fcnt),      96'(m_cnt));
        chk("m_dec_valid", 96'(dec_valid), 96'(ev));
        if (ev) chk("m_dec_bus", dec_bus, mq[0]);
      end
    end
  end

  // Driver: inputs change 1 time unit after the rising edge.
  logic        last_v;
  logic [95:0] last_bus;
  logic [63:0] popped [$];

  task automatic step(input logic rv, input logic [63:0] rp, input logic h, input logic rdy);
    redir = rv; redir_pc = rp; halt = h; dec_ready = rdy;
    #2;
    last_v   = dec_valid;
    last_bus = dec_bus;
    if (dec_valid && rdy) popped.push_back(dec_bus[95:32]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2, 1'b1);
    chk("rst_state",    96'(state),     96'(2'b00));
    chk("rst_pc",       96'(pc_o),      96'(RESET_PC));
    chk("rst_fcnt",     96'(fcnt),      96'd0);
    chk("rst_misalign", 96'(misalign),  96'd0);
    chk("rst_valid",    96'(dec_valid), 96'd0);
    rst = 1'b0;
    popped.delete();
  endtask

  initial begin
    rst = 1'b1; redir = 1'b0; redir_pc = 64'd0; halt = 1'b0; dec_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset release and streaming with decode always ready.
    do_reset();
    step(1'b0, 64'd0, 1'b0, 1'b1);
    chk("boot_valid", 96'(last_v), 96'd0);
    chk("boot_state", 96'(state),  96'(2'b01));
    chk("boot_pc",    96'(pc_o),   96'(RESET_PC));
    step(1'b0, 64'd0, 1'b0, 1'b1);
    chk("first_push_fcnt", 96'(fcnt), 96'd1);
    chk("first_push_pc",   96'(pc_o), 96'h8000_0004);
    idle(3, 1'b1);
    chk("stream_npop", 96'(popped.size()), 96'd3);
    if (popped.size() >= 3) begin
      chk("stream_pc0", 96'(popped[0]), 96'h8000_0000);
      chk("stream_pc1", 96'(popped[1]), 96'h8000_0004);
      chk("stream_pc2", 96'(popped[2]), 96'h8000_0008);
    end
    chk("stream_fcnt", 96'(fcnt), 96'd4);
    chk("stream_pc",   96'(pc_o), 96'h8000_0010);

    // Back-pressure: buffer fills to two entries and holds them.
    do_reset();
    step(1'b0, 64'd0, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("stall_pc",    96'(pc_o),          96'h8000_0008);
    chk("stall_fcnt",  96'(fcnt),          96'd2);
    chk("stall_npop",  96'(popped.size()), 96'd0);
    #2;
    chk("stall_valid", 96'(dec_valid),     96'd1);
    chk("stall_head",  96'(dec_bus),       {64'h8000_0000, instr_of(64'h8000_0000)});
    idle(3, 1'b1);
    chk("drain_npop", 96'(popped.size()), 96'd3);
    if (popped.size() >= 3) begin
      chk("drain_pc0", 96'(popped[0]), 96'h8000_0000);
      chk("drain_pc1", 96'(popped[1]), 96'h8000_0004);
      chk("drain_pc2", 96'(popped[2]), 96'h8000_0008);
    end
    chk("drain_fcnt", 96'(fcnt), 96'd5);

    // Redirect while full: old entries are never delivered.
    popped.delete();
    step(1'b1, 64'h8000_0100, 1'b0, 1'b1);
    chk("redir_valid_same", 96'(last_v), 96'd0);
    chk("redir_pc",         96'(pc_o),   96'h8000_0100);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    chk("redir_valid_next", 96'(last_v), 96'd0);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    chk("redir_npop", 96'(popped.size()), 96'd1);
    if (popped.size() >= 1) chk("redir_first", 96'(popped[0]), 96'h8000_0100);
    chk("redir_fcnt", 96'(fcnt), 96'd7);
    chk("redir_pc2",  96'(pc_o), 96'h8000_0108);

    // PC wraps past the top of the 64-bit space.
    popped.delete();
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    chk("wrap_pc", 96'(pc_o), 96'd0);
    step(1'b0, 64'd0, 1'b0, 1'b1);
    if (popped.size() >= 1) chk("wrap_pop", 96'(popped[0]), 96'hFFFF_FFFF_FFFF_FFFC);
    else chk("wrap_npop", 96'(popped.size()), 96'd1);

    // Halt with one pending entry; later redirect is ignored.
    popped.delete();
    step(1'b0, 64'd0, 1'b1, 1'b1);
    chk("halt_state", 96'(state), 96'(2'b10));
    chk("halt_fcnt",  96'(fcnt),  96'd9);
    step(1'b1, 64'h8000_0300, 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("halt_pc",    96'(pc_o),          96'd4);
    chk("halt_fcnt2", 96'(fcnt),          96'd9);
    chk("halt_npop",  96'(popped.size()), 96'd1);
    if (popped.size() >= 1) chk("halt_pop", 96'(popped[0]), 96'd0);
    chk("halt_valid", 96'(last_v), 96'd0);

    // Mid-stream reset discards a full buffer; then misaligned redirect.
    do_reset();
    step(1'b0, 64'd0, 1'b0, 1'b0);
    idle(3, 1'b0);
    do_reset();
    step(1'b0, 64'd0, 1'b0, 1'b1);
    chk("post_rst_valid", 96'(last_v), 96'd0);
    idle(2, 1'b1);
    step(1'b1, 64'h8000_0102, 1'b0, 1'b1);
    chk("mis_flag",  96'(misalign), 96'd1);
    chk("mis_state", 96'(state),    96'(2'b10));
    chk("mis_pc",    96'(pc_o),     96'h8000_0008);
    chk("mis_fcnt",  96'(fcnt),     96'd2);
    idle(2, 1'b1);
    chk("mis_valid", 96'(last_v), 96'd0);
    chk("mis_pc2",   96'(pc_o),   96'h8000_0008);

    // Aligned redirect together with halt.
    do_reset();
    idle(2, 1'b1);
    step(1'b1, 64'h8000_0200, 1'b1, 1'b1);
    chk("rh_pc",       96'(pc_o),     96'h8000_0200);
    chk("rh_state",    96'(state),    96'(2'b10));
    chk("rh_misalign", 96'(misalign), 96'd0);
    chk("rh_fcnt",     96'(fcnt),     96'd1);
    idle(2, 1'b1);
    chk("rh_valid", 96'(last_v), 96'd0);

    // Halt with a full buffer: both entries still drain in order.
    do_reset();
    step(1'b0, 64'd0, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("hfull_npop", 96'(popped.size()), 96'd2);
    if (popped.size() >= 2) begin
      chk("hfull_pc0", 96'(popped[0]), 96'h8000_0000);
      chk("hfull_pc1", 96'(popped[1]), 96'h8000_0004);
    end
    chk("hfull_fcnt", 96'(fcnt), 96'd2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
